flex_spi_master: RTL and testbench

Parametrised SPI master that generalises the team's single-slave SPI block. It adds a configurable data width, a programmable SCK divider, multiple one-hot active-low slave selects, and per-transfer CPOL/CPHA/length. Separate tx/rx buses replace the shared tristate data bus. It sits between a host-side register/control FSM and external SPI slaves.

---
 rtl/flex_spi_pkg.sv | 20 ++
 rtl/flex_spi_master_clk_div.sv | 39 +++
 rtl/flex_spi_master.sv | 215 +++++++++++++++++++++
 tb/tb_flex_spi_master.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/flex_spi_pkg.sv
// -----------------------------------------------------------------------------
// flex_spi_pkg
// Shared definitions for the flex SPI master:
//   - spi_state_e : transfer FSM states (IDLE, LEAD, SHIFT, TRAIL)
//   - DEF_*       : default parameter values for the master and its divider
// -----------------------------------------------------------------------------
package flex_spi_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_NUM_SS = 4;
    localparam int DEF_DIV_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        SHIFT = 2'd2,
        TRAIL = 2'd3
    } spi_state_e;

endpackage

// File: rtl/flex_spi_master_clk_div.sv
// -----------------------------------------------------------------------------
// spi_clk_div
// Edge-tick generator: while en_i is high, tick_o pulses once every
// clk_div_i+1 cycles. The first tick comes clk_div_i+1 cycles after en_i
// rises; the counter is held at zero while disabled.
// Ports:
//   clk_i     system clock
//   rst_i     synchronous active-high reset
//   en_i      run the counter
//   clk_div_i half-period minus one, in clk cycles
//   tick_o    one-cycle strobe marking the end of each half-period
// -----------------------------------------------------------------------------
module spi_clk_div
    import flex_spi_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] clk_div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == clk_div_i);

    always_comb begin
        cnt_d = cnt_q + DIV_W'(1);
        if (!en_i || tick_o) cnt_d = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/flex_spi_master.sv
// -----------------------------------------------------------------------------
// flex_spi_master
// SPI master with programmable width, SCK divider, CPOL/CPHA and one-hot
// active-low slave selects. All transfer settings are latched on start.
// Build option: define SPI_LSB_FIRST_EN to shift tx/rx LSB first
// (default MSB first). Ports and timing are identical in both builds.
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   start_i       request a transfer (taken while the FSM is idle)
//   ss_sel_i      slave index; out-of-range index asserts no select
//   cpol_i/cpha_i SPI mode
//   xfer_len_i    bit count minus one
//   clk_div_i     SCK half-period minus one, in clk cycles
//   tx_data_i     right-justified transmit word
//   rx_data_o     right-justified received word, loaded with done_o
//   busy_o/done_o transfer status / one-cycle end pulse
//   ss_n_o, sck_o, mosi_o, miso_i  SPI pins
// -----------------------------------------------------------------------------
module flex_spi_master
    import flex_spi_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int NUM_SS = DEF_NUM_SS,
    parameter  int DIV_W  = DEF_DIV_W,
    localparam int LEN_W  = $clog2(DATA_W),
    localparam int SS_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [SS_W-1:0]   ss_sel_i,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic [LEN_W-1:0]  xfer_len_i,
    input  logic [DIV_W-1:0]  clk_div_i,
    input  logic [DATA_W-1:0] tx_data_i,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [NUM_SS-1:0] ss_n_o,
    output logic              sck_o,
    output logic              mosi_o,
    input  logic              miso_i
);

    spi_state_e        state_q, state_d;
    logic [LEN_W-1:0]  len_q;
    logic [DIV_W-1:0]  div_q;
    logic              cpha_q;
    logic [SS_W-1:0]   ss_q;
    logic [DATA_W-1:0] tx_sh_q, rx_sh_q;
    logic [LEN_W+1:0]  ecnt_q;        // SCK edges made so far (0..2N)
    logic              sck_int_q, mosi_int_q;
    logic              samp_q;        // capture miso on this edge
    logic              fin_q;         // FSM just returned to IDLE

    logic              busy_q, done_q, sck_q, mosi_q;
    logic [NUM_SS-1:0] ss_n_q;
    logic [DATA_W-1:0] rx_data_q;
    logic              busy_d, done_d, sck_d, mosi_d;
    logic [NUM_SS-1:0] ss_n_d;

    logic              tick, last_edge, samp_edge;
    logic [LEN_W+1:0]  two_n;
    logic [DATA_W-1:0] tx_mask, tx_load, tx_load_sh, tx_nxt_sh;
    logic              tx_first, tx_cur;

`ifdef SPI_LSB_FIRST_EN
    logic [LEN_W-1:0]  rcnt_q;
`endif

    spi_clk_div #(.DIV_W(DIV_W)) u_clk_div (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .en_i      (state_q != IDLE),
        .clk_div_i (div_q),
        .tick_o    (tick)
    );

    // Internal FSM/datapath run one cycle ahead of the registered pins, so
    // the pin view starts at the edge after start is taken. miso capture is
    // delayed by samp_q to land on the edge where sck_o makes the sample
    // transition.
    assign two_n     = ({2'b00, len_q} + (LEN_W+2)'(1)) << 1;
    assign last_edge = (ecnt_q + (LEN_W+2)'(1)) == two_n;
    assign samp_edge = ~ecnt_q[0] ^ cpha_q;   // odd edges for cpha=0

    // Bits above xfer_len never reach the shifter.
    assign tx_mask = {DATA_W{1'b1}} >> (LEN_W'(DATA_W - 1) - xfer_len_i);
    assign tx_load = tx_data_i & tx_mask;

`ifdef SPI_LSB_FIRST_EN
    assign tx_first   = tx_load[0];
    assign tx_load_sh = tx_load >> 1;
    assign tx_cur     = tx_sh_q[0];
    assign tx_nxt_sh  = tx_sh_q >> 1;
`else
    assign tx_first   = tx_load[xfer_len_i];
    assign tx_load_sh = tx_load << 1;
    assign tx_cur     = tx_sh_q[len_q];
    assign tx_nxt_sh  = tx_sh_q << 1;
`endif

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i)           state_d = LEAD;
            LEAD:    if (tick)              state_d = SHIFT;
            SHIFT:   if (tick && last_edge) state_d = TRAIL;
            TRAIL:   if (tick)              state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    // Output decode (registered below)
    always_comb begin
        busy_d = (state_q != IDLE);
        done_d = fin_q;
        sck_d  = (state_q == IDLE) ? cpol_i : sck_int_q;
        mosi_d = mosi_int_q;
        ss_n_d = '1;
        for (int i = 0; i < NUM_SS; i++)
            ss_n_d[i] = ~(busy_d && (ss_q == SS_W'(i)));
    end

    // Datapath and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            len_q      <= '0;
            div_q      <= '0;
            cpha_q     <= 1'b0;
            ss_q       <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            ecnt_q     <= '0;
            sck_int_q  <= 1'b0;
            mosi_int_q <= 1'b0;
            samp_q     <= 1'b0;
            fin_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ss_n_q     <= '1;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            rx_data_q  <= '0;
`ifdef SPI_LSB_FIRST_EN
            rcnt_q     <= '0;
`endif
        end else begin
            fin_q  <= (state_q == TRAIL) && tick;
            samp_q <= 1'b0;

            if (samp_q) begin
`ifdef SPI_LSB_FIRST_EN
                rx_sh_q[rcnt_q] <= miso_i;
                rcnt_q          <= rcnt_q + LEN_W'(1);
`else
                rx_sh_q <= {rx_sh_q[DATA_W-2:0], miso_i};
`endif
            end

            case (state_q)
                IDLE: if (start_i) begin
                    len_q     <= xfer_len_i;
                    div_q     <= clk_div_i;
                    cpha_q    <= cpha_i;
                    ss_q      <= ss_sel_i;
                    sck_int_q <= cpol_i;
                    ecnt_q    <= '0;
                    rx_sh_q   <= '0;
`ifdef SPI_LSB_FIRST_EN
                    rcnt_q    <= '0;
`endif
                    // cpha=0 presents bit 0 now; cpha=1 waits for the leading edge
                    mosi_int_q <= cpha_i ? 1'b0    : tx_first;
                    tx_sh_q    <= cpha_i ? tx_load : tx_load_sh;
                end
                SHIFT: if (tick) begin
                    ecnt_q    <= ecnt_q + (LEN_W+2)'(1);
                    sck_int_q <= ~sck_int_q;
                    if (samp_edge) begin
                        samp_q <= 1'b1;
                    end else begin
                        mosi_int_q <= tx_cur;
                        tx_sh_q    <= tx_nxt_sh;
                    end
                end
                default: ;
            endcase

            if (fin_q) rx_data_q <= rx_sh_q;

            busy_q <= busy_d;
            done_q <= done_d;
            ss_n_q <= ss_n_d;
            sck_q  <= sck_d;
            mosi_q <= mosi_d;
        end
    end

    assign rx_data_o = rx_data_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign ss_n_o    = ss_n_q;
    assign sck_o     = sck_q;
    assign mosi_o    = mosi_q;

endmodule

// File: tb/tb_flex_spi_master.sv
// -----------------------------------------------------------------------------
// tb_flex_spi_master
// Scoreboard bench: each accepted start pushes the expected rx word, slave
// select pattern and start-to-done latency; the monitor pops on done.
// -----------------------------------------------------------------------------
module tb_flex_spi_master;

    localparam int DATA_W = 16;
    localparam int NUM_SS = 5;
    localparam int DIV_W  = 8;
    localparam int LEN_W  = $clog2(DATA_W);
    localparam int SS_W   = $clog2(NUM_SS);

    logic              clk = 1'b0;
    logic              rst, start, cpol, cpha, miso, mosi, sck, busy, done;
    logic              miso_val, loop;
    logic [SS_W-1:0]   ss_sel;
    logic [LEN_W-1:0]  xfer_len;
    logic [DIV_W-1:0]  clk_div;
    logic [DATA_W-1:0] tx_data, rx_data;
    logic [NUM_SS-1:0] ss_n;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    assign miso = loop ? mosi : miso_val;

    flex_spi_master #(.DATA_W(DATA_W), .NUM_SS(NUM_SS), .DIV_W(DIV_W)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .ss_sel_i   (ss_sel),
        .cpol_i     (cpol),
        .cpha_i     (cpha),
        .xfer_len_i (xfer_len),
        .clk_div_i  (clk_div),
        .tx_data_i  (tx_data),
        .rx_data_o  (rx_data),
        .busy_o     (busy),
        .done_o     (done),
        .ss_n_o     (ss_n),
        .sck_o      (sck),
        .mosi_o     (mosi),
        .miso_i     (miso)
    );

    typedef struct {
        logic [DATA_W-1:0] rx;
        logic [NUM_SS-1:0] ss;
        int                lat;
        int                scyc;
    } exp_t;

    exp_t sb[$];
    int   nchk = 0;
    int   nerr = 0;

    task automatic chk(input string tag, input int act, input int exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: tracks each busy window and scores it when done pulses.
    logic              in_busy = 1'b0;
    logic              ss_var  = 1'b0;
    int                bcyc    = 0;
    logic [NUM_SS-1:0] ss_seen = '1;
    exp_t              m;

    always @(negedge clk) begin
        if (rst) begin
            in_busy = 1'b0;
        end else begin
            if (busy) begin
                if (!in_busy) begin
                    in_busy = 1'b1;
                    bcyc    = 1;
                    ss_seen = ss_n;
                    ss_var  = 1'b0;
                end else begin
                    bcyc++;
                    if (ss_n !== ss_seen) ss_var = 1'b1;
                end
            end
            if (done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", done, 0);
                end else begin
                    m = sb.pop_front();
                    chk("rx_data",   rx_data,          m.rx);
                    chk("latency",   cyc - 1 - m.scyc, m.lat);
                    chk("ss_n",      ss_seen,          m.ss);
                    chk("ss_stable", ss_var,           0);
                    chk("busy_len",  bcyc,             m.lat - 1);
                end
                in_busy = 1'b0;
            end
        end
    end

    task automatic xfer(input int len, input logic [DATA_W-1:0] tx, input int ss,
                        input logic p, input logic h, input int div,
                        input logic lp, input logic mv, input logic mess);
        exp_t              e;
        logic [DATA_W-1:0] mask;
        logic              first;
        int                w;
        mask     = DATA_W'((32'd1 << (len + 1)) - 1);
`ifdef SPI_LSB_FIRST_EN
        first    = tx[0];
`else
        first    = tx[len];
`endif
        xfer_len = LEN_W'(len);
        tx_data  = tx;
        ss_sel   = SS_W'(ss);
        cpol     = p;
        cpha     = h;
        clk_div  = DIV_W'(div);
        loop     = lp;
        miso_val = mv;
        tick(1);
        e.rx   = lp ? (tx & mask) : (mv ? mask : '0);
        e.ss   = (ss < NUM_SS) ? ~(NUM_SS'(1) << ss) : '1;
        e.lat  = 1 + (div + 1) * (2 * (len + 1) + 2);
        e.scyc = cyc;
        sb.push_back(e);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(1);
        if (!h) chk("mosi_first", mosi, first);
        if (mess) begin
            // Everything below must be ignored by the running transfer.
            tx_data  = ~tx;
            xfer_len = '1;
            ss_sel   = SS_W'(ss + 1);
            cpol     = ~p;
            cpha     = ~h;
            clk_div  = '0;
            start    = 1'b1;
            tick(1);
            start    = 1'b0;
        end
        w = 0;
        while (sb.size() != 0 && w < 5000) begin
            tick(1);
            w++;
        end
        chk("timeout", sb.size(), 0);
        sb.delete();
        tick(2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   w, s;
        rst = 1'b1; start = 1'b0; cpol = 1'b0; cpha = 1'b0; loop = 1'b0;
        miso_val = 1'b0; ss_sel = '0; xfer_len = '0; clk_div = '0; tx_data = '0;
        tick(3);
        chk("rst_busy", busy,    0);
        chk("rst_done", done,    0);
        chk("rst_rx",   rx_data, 0);
        chk("rst_ss_n", ss_n,    32'h1f);
        chk("rst_sck",  sck,     0);
        chk("rst_mosi", mosi,    0);
        rst = 1'b0;
        tick(2);

        // Mode 0 loopback, upper tx bits must be ignored
        xfer(7, 16'hFFA5, 0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);

        // Mode 3, miso held high
        cpol = 1'b1;
        tick(2);
        chk("sck_idle_hi", sck, 1);
        xfer(11, 16'h0AAA, 0, 1'b1, 1'b1, 2, 1'b0, 1'b1, 1'b0);

        // Mode 1 full-width loopback, single-bit transfer
        xfer(15, 16'hC3A5, 1, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0);
        xfer(0,  16'h0001, 3, 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b0);

        // Slave 2 with inputs disturbed mid-transfer, then out-of-range slave
        xfer(4, 16'h0015, 2, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b1);
        xfer(7, 16'h005A, 5, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);

        // Back-to-back with start held high
        xfer_len = 7; tx_data = 16'h003C; ss_sel = 1; cpol = 1'b0; cpha = 1'b0;
        clk_div = 0; loop = 1'b1;
        tick(1);
        e.rx = 16'h003C; e.ss = 5'b11101; e.lat = 19;
        e.scyc = cyc;      sb.push_back(e);
        e.scyc = cyc + 19; sb.push_back(e);
        start = 1'b1;
        w = 0;
        while (sb.size() > 1 && w < 500) begin
            tick(1);
            w++;
        end
        start = 1'b0;
        w = 0;
        while (sb.size() != 0 && w < 500) begin
            tick(1);
            w++;
        end
        chk("b2b_timeout", sb.size(), 0);
        sb.delete();
        tick(5);

        // Reset in the middle of SHIFT: no done, everything back to reset
        xfer_len = 7; tx_data = 16'h00F0; ss_sel = 0; cpol = 1'b1; cpha = 1'b0;
        clk_div = 0; loop = 1'b1;
        tick(2);
        s = cyc;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        while (cyc < s + 9) tick(1);
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_sck",  sck,  1);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_ss_n", ss_n,    32'h1f);
        chk("mid_rst_busy", busy,    0);
        chk("mid_rst_sck",  sck,     0);
        chk("mid_rst_done", done,    0);
        chk("mid_rst_rx",   rx_data, 0);
        rst = 1'b0;
        tick(40);

        // Recovery after reset
        xfer(9, 16'h0236, 4, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0);

        chk("sb_left", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
